// File: rtl/spi_pacer_pkg.sv
// Shared types and constants for the SPI byte pacer.
// The state encoding is fixed so that it reads the same in waveforms and debug logs.
package spi_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } pacer_state_e;

  // The downstream sender needs 18 cycles per byte plus some margin.
  localparam int LP_MIN_BYTE_PERIOD = 20;
  localparam int LP_SENT_CNT_WIDTH  = 16;
  localparam int LP_PCNT_WIDTH      = 8;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead FIFO with registered pointers and flags and a synchronous flush.
// The head entry is visible on head_o whenever empty_o is low.
module byte_fifo #(
  parameter  int P_WIDTH = 8,
  parameter  int P_DEPTH = 16,
  localparam int LP_AW   = $clog2(P_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic [P_WIDTH-1:0] data_i,
  input  logic               pop_i,
  output logic [P_WIDTH-1:0] head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LP_AW:0]     level_o
);

  localparam logic [LP_AW:0] LP_FULL = (LP_AW + 1)'(P_DEPTH);

  generate
    if (P_DEPTH < 2 || (1 << LP_AW) != P_DEPTH) begin : g_depth_check
      $error("byte_fifo: P_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic [LP_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LP_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LP_AW:0]     count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;

  // A flush wins over any push or pop issued in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + LP_AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + LP_AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + (LP_AW + 1)'(1);
        2'b01:   count_d = count_q - (LP_AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == LP_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = count_q;

endmodule

// File: rtl/spi_byte_pacer.sv
// Buffers upstream bytes and replays them to the SPI byte sender as
// fixed-width valid pulses, one per byte period.
module spi_byte_pacer
  import spi_pacer_pkg::*;
#(
  parameter  int P_DATA_WIDTH   = 8,
  parameter  int P_FIFO_DEPTH   = 16,
  parameter  int P_PULSE_CYCLES = 2,
  parameter  int P_BYTE_PERIOD  = 24,
  localparam int LP_LEVEL_W     = $clog2(P_FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [P_DATA_WIDTH-1:0]      s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         clear,
  output logic                         tx_valid,
  output logic [P_DATA_WIDTH-1:0]      tx_data,
  output logic                         busy,
  output logic [LP_LEVEL_W-1:0]        fifo_level,
  output logic [LP_SENT_CNT_WIDTH-1:0] sent_cnt
);

  localparam logic [LP_PCNT_WIDTH-1:0] LP_PULSE_LAST  = LP_PCNT_WIDTH'(P_PULSE_CYCLES - 1);
  localparam logic [LP_PCNT_WIDTH-1:0] LP_PERIOD_LAST = LP_PCNT_WIDTH'(P_BYTE_PERIOD - 1);

  generate
    if (P_BYTE_PERIOD < LP_MIN_BYTE_PERIOD) begin : g_period_check
      $error("spi_byte_pacer: P_BYTE_PERIOD must be at least 20");
    end
    if (P_BYTE_PERIOD > (1 << LP_PCNT_WIDTH)) begin : g_period_range_check
      $error("spi_byte_pacer: P_BYTE_PERIOD does not fit the period counter");
    end
    if (P_PULSE_CYCLES < 1) begin : g_pulse_min_check
      $error("spi_byte_pacer: P_PULSE_CYCLES must be at least 1");
    end
    if (P_PULSE_CYCLES > P_BYTE_PERIOD - 2) begin : g_pulse_max_check
      $error("spi_byte_pacer: P_PULSE_CYCLES must not exceed P_BYTE_PERIOD-2");
    end
    if (P_DATA_WIDTH != 8) begin : g_width_check
      $error("spi_byte_pacer: the downstream sender only supports 8-bit bytes");
    end
  endgenerate

  pacer_state_e                   state_q, state_d;
  logic [LP_PCNT_WIDTH-1:0]       pcnt_q, pcnt_d;
  logic                           tx_valid_q, tx_valid_d;
  logic [P_DATA_WIDTH-1:0]        tx_data_q, tx_data_d;
  logic [LP_SENT_CNT_WIDTH-1:0]   sent_cnt_q, sent_cnt_d;

  logic                           fifo_push;
  logic                           fifo_pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [P_DATA_WIDTH-1:0]        fifo_head;

  // Pop depends only on registered state, so s_ready never loops back through s_valid.
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign s_ready   = !fifo_full || fifo_pop;
  assign fifo_push = s_valid && s_ready;

  byte_fifo #(
    .P_WIDTH (P_DATA_WIDTH),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .push_i  (fifo_push),
    .data_i  (s_data),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // The period counter runs across PULSE and GAP, so the edge spacing is one period plus the IDLE cycle.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    sent_cnt_d = sent_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          tx_data_d  = fifo_head;
          tx_valid_d = 1'b1;
          pcnt_d     = '0;
          sent_cnt_d = sent_cnt_q + LP_SENT_CNT_WIDTH'(1);
          state_d    = ST_PULSE;
        end
      end
      ST_PULSE: begin
        pcnt_d = pcnt_q + LP_PCNT_WIDTH'(1);
        if (pcnt_q == LP_PULSE_LAST) begin
          tx_valid_d = 1'b0;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        pcnt_d = pcnt_q + LP_PCNT_WIDTH'(1);
        if (pcnt_q == LP_PERIOD_LAST) begin
          pcnt_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        pcnt_d     = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pcnt_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      sent_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign sent_cnt = sent_cnt_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_spi_byte_pacer.sv
// Directed bench for spi_byte_pacer at default parameters (depth 16, pulse 2, period 24).
// Rising edges of tx_valid are logged by a monitor and checked per scenario.
module tb_spi_byte_pacer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       clear = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
  logic [4:0] fifo_level;
  logic [15:0] sent_cnt;

  int nVectors = 0;
  int nMiscompares = 0;
  int cyc = 0;
  int riseCyc[$];
  logic [7:0] riseData[$];
  logic prevValid = 1'b0;

  spi_byte_pacer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .clear      (clear),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .busy       (busy),
    .fifo_level (fifo_level),
    .sent_cnt   (sent_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Logs every tx_valid rising edge the way the downstream edge detector would see it.
  always @(negedge clk) begin
    if (tx_valid === 1'b1 && prevValid !== 1'b1) begin
      riseCyc.push_back(cyc);
      riseData.push_back(tx_data);
    end
    prevValid = tx_valid;
  end

  task tick();
    @(posedge clk);
    #1;
  endtask

  task doReset();
    s_valid = 1'b0;
    clear = 1'b0;
    s_data = 8'h00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    riseCyc.delete();
    riseData.delete();
  endtask

  task test_reset();
    #2 rst_n = 1'b0;
    #1;
    nVectors++; if (s_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_s_ready: got %b expected 1", s_ready); end
    nVectors++; if (tx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    nVectors++; if (tx_data !== 8'h00) begin nMiscompares++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    nVectors++; if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    nVectors++; if (fifo_level !== 5'd0) begin nMiscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
    nVectors++; if (sent_cnt !== 16'd0) begin nMiscompares++; $display("[TB] FAIL reset_sent_cnt: got %0d expected 0", sent_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task test_single();
    doReset();
    repeat (9) tick();
    s_data = 8'hA5;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    nVectors++; if (tx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL single_latency: got %b expected 0", tx_valid); end
    nVectors++; if (fifo_level !== 5'd1) begin nMiscompares++; $display("[TB] FAIL single_level: got %0d expected 1", fifo_level); end
    nVectors++; if (busy !== 1'b1) begin nMiscompares++; $display("[TB] FAIL single_busy_early: got %b expected 1", busy); end
    tick();
    nVectors++; if (tx_valid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL single_rise: got %b expected 1", tx_valid); end
    nVectors++; if (tx_data !== 8'hA5) begin nMiscompares++; $display("[TB] FAIL single_data: got %h expected a5", tx_data); end
    nVectors++; if (sent_cnt !== 16'd1) begin nMiscompares++; $display("[TB] FAIL single_sent: got %0d expected 1", sent_cnt); end
    nVectors++; if (fifo_level !== 5'd0) begin nMiscompares++; $display("[TB] FAIL single_level_pop: got %0d expected 0", fifo_level); end
    tick();
    nVectors++; if (tx_valid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL single_pulse2: got %b expected 1", tx_valid); end
    tick();
    nVectors++; if (tx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL single_pulse_end: got %b expected 0", tx_valid); end
    repeat (21) tick();
    nVectors++; if (busy !== 1'b1) begin nMiscompares++; $display("[TB] FAIL single_busy_gap: got %b expected 1", busy); end
    tick();
    nVectors++; if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL single_busy_end: got %b expected 0", busy); end
    nVectors++; if (tx_data !== 8'hA5) begin nMiscompares++; $display("[TB] FAIL single_data_hold: got %h expected a5", tx_data); end
  endtask

  task test_burst();
    int peak;
    int pushCyc;
    int waited;
    doReset();
    peak = 0;
    pushCyc = 0;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'(i + 1);
      s_valid = 1'b1;
      tick();
      if (i == 0) pushCyc = cyc;
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    s_valid = 1'b0;
    waited = 0;
    while (riseCyc.size() < 5 && waited < 300) begin
      tick();
      waited++;
    end
    nVectors++; if (riseCyc.size() != 5) begin nMiscompares++; $display("[TB] FAIL burst_count: got %0d edges expected 5", riseCyc.size()); end
    nVectors++; if (peak != 4) begin nMiscompares++; $display("[TB] FAIL burst_peak_level: got %0d expected 4", peak); end
    nVectors++; if (sent_cnt !== 16'd5) begin nMiscompares++; $display("[TB] FAIL burst_sent: got %0d expected 5", sent_cnt); end
    if (riseCyc.size() > 0) begin
      nVectors++; if (riseCyc[0] - pushCyc != 1) begin nMiscompares++; $display("[TB] FAIL burst_first_latency: got %0d expected 1", riseCyc[0] - pushCyc); end
    end
    for (int i = 0; i < riseData.size(); i++) begin
      nVectors++; if (riseData[i] !== 8'(i + 1)) begin nMiscompares++; $display("[TB] FAIL burst_data[%0d]: got %h expected %h", i, riseData[i], 8'(i + 1)); end
      if (i > 0) begin
        nVectors++; if (riseCyc[i] - riseCyc[i-1] != 25) begin nMiscompares++; $display("[TB] FAIL burst_spacing[%0d]: got %0d expected 25", i, riseCyc[i] - riseCyc[i-1]); end
      end
    end
  endtask

  task test_full();
    int idx;
    int waited;
    logic acc;
    doReset();
    idx = 0;
    for (int t = 0; t < 200 && idx < 20; t++) begin
      s_valid = 1'b1;
      s_data = 8'(8'h10 + idx);
      acc = s_ready;
      tick();
      if (acc) idx++;
      if (t == 16) begin
        nVectors++; if (fifo_level !== 5'd16) begin nMiscompares++; $display("[TB] FAIL full_level: got %0d expected 16", fifo_level); end
        nVectors++; if (s_ready !== 1'b0) begin nMiscompares++; $display("[TB] FAIL full_backpressure: got %b expected 0", s_ready); end
        nVectors++; if (idx != 17) begin nMiscompares++; $display("[TB] FAIL full_accepted: got %0d expected 17", idx); end
      end
      if (t == 25) begin
        nVectors++; if (s_ready !== 1'b1) begin nMiscompares++; $display("[TB] FAIL full_pop_ready: got %b expected 1", s_ready); end
        nVectors++; if (fifo_level !== 5'd16) begin nMiscompares++; $display("[TB] FAIL full_level_idle: got %0d expected 16", fifo_level); end
      end
      if (t == 26) begin
        nVectors++; if (fifo_level !== 5'd16) begin nMiscompares++; $display("[TB] FAIL full_pushpop_level: got %0d expected 16", fifo_level); end
        nVectors++; if (tx_data !== 8'h11) begin nMiscompares++; $display("[TB] FAIL full_pushpop_data: got %h expected 11", tx_data); end
        nVectors++; if (idx != 18) begin nMiscompares++; $display("[TB] FAIL full_pushpop_accept: got %0d expected 18", idx); end
      end
    end
    s_valid = 1'b0;
    nVectors++; if (idx != 20) begin nMiscompares++; $display("[TB] FAIL full_all_accepted: got %0d expected 20", idx); end
    waited = 0;
    while (riseData.size() < 20 && waited < 700) begin
      tick();
      waited++;
    end
    repeat (30) tick();
    nVectors++; if (riseData.size() != 20) begin nMiscompares++; $display("[TB] FAIL full_delivered: got %0d expected 20", riseData.size()); end
    for (int i = 0; i < riseData.size(); i++) begin
      nVectors++; if (riseData[i] !== 8'(8'h10 + i)) begin nMiscompares++; $display("[TB] FAIL full_order[%0d]: got %h expected %h", i, riseData[i], 8'(8'h10 + i)); end
    end
    nVectors++; if (sent_cnt !== 16'd20) begin nMiscompares++; $display("[TB] FAIL full_sent: got %0d expected 20", sent_cnt); end
    nVectors++; if (fifo_level !== 5'd0) begin nMiscompares++; $display("[TB] FAIL full_drained: got %0d expected 0", fifo_level); end
  endtask

  task test_clear();
    doReset();
    for (int i = 0; i < 3; i++) begin
      s_data = 8'(8'h31 + i);
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h99;
    tick();
    clear = 1'b0;
    s_valid = 1'b0;
    nVectors++; if (fifo_level !== 5'd0) begin nMiscompares++; $display("[TB] FAIL clear_level: got %0d expected 0", fifo_level); end
    nVectors++; if (busy !== 1'b1) begin nMiscompares++; $display("[TB] FAIL clear_busy_gap: got %b expected 1", busy); end
    repeat (18) tick();
    nVectors++; if (busy !== 1'b1) begin nMiscompares++; $display("[TB] FAIL clear_period_runs: got %b expected 1", busy); end
    tick();
    nVectors++; if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL clear_period_end: got %b expected 0", busy); end
    repeat (40) tick();
    nVectors++; if (riseData.size() != 1) begin nMiscompares++; $display("[TB] FAIL clear_edges: got %0d expected 1", riseData.size()); end
    if (riseData.size() > 0) begin
      nVectors++; if (riseData[0] !== 8'h31) begin nMiscompares++; $display("[TB] FAIL clear_first_byte: got %h expected 31", riseData[0]); end
    end
    nVectors++; if (tx_data !== 8'h31) begin nMiscompares++; $display("[TB] FAIL clear_data_hold: got %h expected 31", tx_data); end
    nVectors++; if (sent_cnt !== 16'd1) begin nMiscompares++; $display("[TB] FAIL clear_sent: got %0d expected 1", sent_cnt); end
    nVectors++; if (fifo_level !== 5'd0) begin nMiscompares++; $display("[TB] FAIL clear_level_end: got %0d expected 0", fifo_level); end
  endtask

  task test_async_reset();
    doReset();
    s_data = 8'h5A;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    nVectors++; if (tx_valid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL areset_pulse: got %b expected 1", tx_valid); end
    #2 rst_n = 1'b0;
    #1;
    nVectors++; if (tx_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL areset_tx_valid: got %b expected 0", tx_valid); end
    nVectors++; if (sent_cnt !== 16'd0) begin nMiscompares++; $display("[TB] FAIL areset_sent: got %0d expected 0", sent_cnt); end
    nVectors++; if (tx_data !== 8'h00) begin nMiscompares++; $display("[TB] FAIL areset_tx_data: got %h expected 00", tx_data); end
    nVectors++; if (busy !== 1'b0) begin nMiscompares++; $display("[TB] FAIL areset_busy: got %b expected 0", busy); end
    tick();
    rst_n = 1'b1;
    tick();
    riseData.delete();
    riseCyc.delete();
    s_data = 8'hC3;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    nVectors++; if (tx_valid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL areset_next_valid: got %b expected 1", tx_valid); end
    nVectors++; if (tx_data !== 8'hC3) begin nMiscompares++; $display("[TB] FAIL areset_next_data: got %h expected c3", tx_data); end
    nVectors++; if (sent_cnt !== 16'd1) begin nMiscompares++; $display("[TB] FAIL areset_next_sent: got %0d expected 1", sent_cnt); end
  endtask

  initial begin
    $display("[TB] spi_byte_pacer directed bench starting");
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
